// File: rtl/writeback_arbiter.sv
// Two-source register-file writeback arbiter: per-source FIFOs, round-robin grant on ties,
// registered write port that idles at zero, and a combinational pending-write scoreboard.
module writeback_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [63:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [63:0] ld_data,
    output logic [63:0] wb_reg_addr,
    output logic [63:0] wb_data,
    output logic        wb_valid,
    output logic [31:0] pending_mask
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Index 0 is the ALU source, index 1 is the load source.
    logic [4:0]      rd_mem   [2][DEPTH];
    logic [63:0]     data_mem [2][DEPTH];
    logic [PtrW-1:0] wptr_q [2];
    logic [PtrW-1:0] wptr_d [2];
    logic [PtrW-1:0] rptr_q [2];
    logic [PtrW-1:0] rptr_d [2];
    logic [CntW-1:0] cnt_q  [2];
    logic [CntW-1:0] cnt_d  [2];
    logic            last_grant_q, last_grant_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [63:0]     wb_data_q, wb_data_d;

    logic [1:0]      in_valid, ready, push, pop, nonempty;
    logic [4:0]      in_rd   [2];
    logic [63:0]     in_data [2];
    logic            grant_any, grant_sel;
    logic [PtrW-1:0] idx;
    logic [31:0]     pending;

    always_comb begin
        in_valid   = {ld_valid, alu_valid};
        in_rd[0]   = alu_rd;
        in_rd[1]   = ld_rd;
        in_data[0] = alu_data;
        in_data[1] = ld_data;
        for (int s = 0; s < 2; s++) begin
            ready[s]    = cnt_q[s] < CntW'(DEPTH);
            nonempty[s] = cnt_q[s] != '0;
            push[s]     = in_valid[s] && ready[s];
        end
    end

    assign alu_ready = ready[0];
    assign ld_ready  = ready[1];

    // On a tie the source that did not win last time goes; otherwise whichever is non-empty.
    always_comb begin
        grant_any    = |nonempty;
        grant_sel    = (&nonempty) ? ~last_grant_q : nonempty[1];
        pop          = '0;
        last_grant_d = last_grant_q;
        wb_valid_d   = grant_any;
        wb_rd_d      = '0;
        wb_data_d    = '0;
        if (grant_any) begin
            pop[grant_sel] = 1'b1;
            last_grant_d   = grant_sel;
            wb_rd_d        = rd_mem[grant_sel][rptr_q[grant_sel]];
            wb_data_d      = data_mem[grant_sel][rptr_q[grant_sel]];
        end
        for (int s = 0; s < 2; s++) begin
            cnt_d[s]  = cnt_q[s] + CntW'(push[s]) - CntW'(pop[s]);
            wptr_d[s] = push[s] ? wptr_q[s] + PtrW'(1) : wptr_q[s];
            rptr_d[s] = pop[s] ? rptr_q[s] + PtrW'(1) : rptr_q[s];
        end
    end

    // Storage is not reset; counts and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                rd_mem[s][wptr_q[s]]   <= in_rd[s];
                data_mem[s][wptr_q[s]] <= (in_rd[s] == 5'd0) ? 64'd0 : in_data[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s]  <= '0;
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
            end
            last_grant_q <= 1'b1;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s]  <= cnt_d[s];
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
            end
            last_grant_q <= last_grant_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

    // Live entries sit at rptr, rptr+1, ... for cnt slots.
    always_comb begin
        pending = '0;
        idx     = '0;
        for (int s = 0; s < 2; s++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = rptr_q[s] + PtrW'(i);
                if (CntW'(i) < cnt_q[s]) begin
                    pending[rd_mem[s][idx]] = 1'b1;
                end
            end
        end
        if (wb_valid_q) begin
            pending[wb_rd_q] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign pending_mask = pending;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_addr  = {59'd0, wb_rd_q};
    assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_writeback_arbiter;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid;
    logic        alu_ready, ld_ready;
    logic [4:0]  alu_rd, ld_rd;
    logic [63:0] alu_data, ld_data;
    logic [63:0] wb_reg_addr, wb_data;
    logic        wb_valid;
    logic [31:0] pending_mask;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .wb_reg_addr  (wb_reg_addr),
        .wb_data      (wb_data),
        .wb_valid     (wb_valid),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per source, a presented-write register and the tie pointer.
    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        q_alu[$];
    ent_t        q_ld[$];
    bit          m_last  = 1'b1;
    bit          m_valid = 1'b0;
    logic [4:0]  m_rd    = '0;
    logic [63:0] m_data  = '0;
    bit          ra, rl, ga, gl;
    ent_t        e;

    always @(posedge clk) begin
        if (reset) begin
            q_alu.delete();
            q_ld.delete();
            m_last  = 1'b1;
            m_valid = 1'b0;
            m_rd    = '0;
            m_data  = '0;
        end else begin
            ra = q_alu.size() < DEPTH;
            rl = q_ld.size() < DEPTH;
            ga = 1'b0;
            gl = 1'b0;
            if (q_alu.size() > 0 && q_ld.size() > 0) begin
                if (m_last) ga = 1'b1;
                else gl = 1'b1;
            end else if (q_alu.size() > 0) begin
                ga = 1'b1;
            end else if (q_ld.size() > 0) begin
                gl = 1'b1;
            end
            if (ga) begin
                e = q_alu.pop_front();
                m_last = 1'b0;
            end else if (gl) begin
                e = q_ld.pop_front();
                m_last = 1'b1;
            end
            m_valid = ga || gl;
            m_rd    = m_valid ? e.rd : 5'd0;
            m_data  = m_valid ? e.data : 64'd0;
            if (alu_valid && ra) q_alu.push_back({alu_rd, (alu_rd == 5'd0) ? 64'd0 : alu_data});
            if (ld_valid && rl) q_ld.push_back({ld_rd, (ld_rd == 5'd0) ? 64'd0 : ld_data});
        end
    end

    function automatic logic [31:0] model_pend();
        logic [31:0] p = '0;
        foreach (q_alu[i]) p[q_alu[i].rd] = 1'b1;
        foreach (q_ld[i]) p[q_ld[i].rd] = 1'b1;
        if (m_valid) p[m_rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    bit check_en  = 1'b0;
    bit bp_log_en = 1'b0;
    int bp_log[$];

    always @(negedge clk) begin
        if (check_en) begin
            chk("wb_valid", {63'd0, wb_valid}, {63'd0, m_valid});
            chk("wb_reg_addr", wb_reg_addr, {59'd0, m_rd});
            chk("wb_data", wb_data, m_data);
            chk("pending_mask", {32'd0, pending_mask}, {32'd0, model_pend()});
            chk("alu_ready", {63'd0, alu_ready}, {63'd0, q_alu.size() < DEPTH});
            chk("ld_ready", {63'd0, ld_ready}, {63'd0, q_ld.size() < DEPTH});
            if (bp_log_en && wb_valid && wb_reg_addr >= 7 && wb_reg_addr <= 10)
                bp_log.push_back(int'(wb_reg_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        alu_rd    = '0;
        ld_rd     = '0;
        alu_data  = '0;
        ld_data   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    bit saw_stall;
    int idx;
    bit acc_a, acc_l;

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        check_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
        chk("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
        chk("rst_pending", {32'd0, pending_mask}, 64'd0);

        // Idle
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", {63'd0, wb_valid}, 64'd0);
            chk("idle_addr", wb_reg_addr, 64'd0);
            chk("idle_data", wb_data, 64'd0);
            chk("idle_pending", {32'd0, pending_mask}, 64'd0);
        end

        // Single write
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 64'hDEAD_BEEF;
        tick();
        idle_inputs();
        chk("single_pend_n", {32'd0, pending_mask}, 64'h20);
        chk("model_pend_n", {32'd0, model_pend()}, 64'h20);
        tick();
        chk("single_valid", {63'd0, wb_valid}, 64'd1);
        chk("single_addr", wb_reg_addr, 64'd5);
        chk("single_data", wb_data, 64'hDEAD_BEEF);
        chk("single_pend_n1", {32'd0, pending_mask}, 64'h20);
        tick();
        chk("single_pend_n2", {32'd0, pending_mask}, 64'd0);
        chk("single_done_valid", {63'd0, wb_valid}, 64'd0);
        chk("single_done_data", wb_data, 64'd0);

        // Ties alternate, ALU first after reset
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
        ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 64'h22;
        tick();
        idle_inputs();
        tick();
        chk("tie1_addr", wb_reg_addr, 64'd1);
        chk("tie1_data", wb_data, 64'h11);
        chk("model_tie1", {59'd0, m_rd}, 64'd1);
        tick();
        chk("tie2_addr", wb_reg_addr, 64'd2);
        chk("tie2_data", wb_data, 64'h22);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
        ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 64'h44;
        tick();
        idle_inputs();
        tick();
        chk("tie3_addr", wb_reg_addr, 64'd3);
        tick();
        chk("tie4_addr", wb_reg_addr, 64'd4);

        // Writes to x0 are presented with zero data and never flagged pending
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 64'hFFFF;
        tick();
        idle_inputs();
        chk("x0_pend_q", {32'd0, pending_mask}, 64'd0);
        tick();
        chk("x0_valid", {63'd0, wb_valid}, 64'd1);
        chk("x0_addr", wb_reg_addr, 64'd0);
        chk("x0_data", wb_data, 64'd0);
        chk("x0_pend_wb", {32'd0, pending_mask}, 64'd0);
        tick();

        // Backpressure: load holds rd 7..10 while ALU floods
        do_reset();
        bp_log.delete();
        bp_log_en = 1'b1;
        saw_stall = 1'b0;
        idx = 0;
        alu_rd   = 5'($urandom_range(11, 31));
        alu_data = {$urandom, $urandom};
        ld_data  = {$urandom, $urandom};
        for (int c = 0; c < 60 && idx < 4; c++) begin
            alu_valid = 1'b1;
            ld_valid  = 1'b1;
            ld_rd     = 5'(7 + idx);
            acc_a     = alu_ready;
            acc_l     = ld_ready;
            if (!ld_ready) saw_stall = 1'b1;
            tick();
            if (acc_l) begin
                idx++;
                ld_data = {$urandom, $urandom};
            end
            if (acc_a) begin
                alu_rd   = 5'($urandom_range(11, 31));
                alu_data = {$urandom, $urandom};
            end
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) tick();
        bp_log_en = 1'b0;
        chk("bp_accepted", 64'(idx), 64'd4);
        chk("bp_saw_stall", {63'd0, saw_stall}, 64'd1);
        chk("bp_count", 64'(bp_log.size()), 64'd4);
        for (int i = 0; i < bp_log.size() && i < 4; i++)
            chk("bp_order", 64'(bp_log[i]), 64'(7 + i));

        // Reset mid-operation discards queued work
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1; alu_rd = 5'($urandom_range(1, 15)); alu_data = {$urandom, $urandom};
            ld_valid  = 1'b1; ld_rd  = 5'($urandom_range(16, 31)); ld_data = {$urandom, $urandom};
            tick();
        end
        chk("pre_reset_busy", {63'd0, pending_mask != 32'd0}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        chk("mid_rst_valid", {63'd0, wb_valid}, 64'd0);
        chk("mid_rst_pend", {32'd0, pending_mask}, 64'd0);
        chk("mid_rst_alu_ready", {63'd0, alu_ready}, 64'd1);
        chk("mid_rst_ld_ready", {63'd0, ld_ready}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_valid", {63'd0, wb_valid}, 64'd0);
        end

        // Randomized traffic; disjoint rd ranges keep same-rd writes off both ports
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 63) == 0);
            alu_valid = ($urandom_range(0, 3) != 0);
            ld_valid  = ($urandom_range(0, 2) != 0);
            alu_rd    = 5'($urandom_range(0, 15));
            ld_rd     = 5'($urandom_range(16, 31));
            alu_data  = {$urandom, $urandom};
            ld_data   = {$urandom, $urandom};
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 6; i++) tick();
        chk("drain_pend", {32'd0, pending_mask}, 64'd0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning entries per source queue (power of two, at least 2).
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Ports alu_valid, input, 1 / alu_ready, output, 1 / alu_rd, input, 5 / alu_data, input, 64: ALU result producer handshake.
REQ-005 Ports ld_valid, input, 1 / ld_ready, output, 1 / ld_rd, input, 5 / ld_data, input, 64: load result producer handshake.
REQ-006 Port wb_reg_addr, output, 64 bits: register-file write address, zero-extended from 5 bits.
REQ-007 Port wb_data, output, 64 bits: register-file write data.
REQ-008 Port wb_valid, output, 1 bit: a real retirement write is presented this cycle.
REQ-009 Port pending_mask, output, 32 bits: bit r set while a write to xr is queued or presented.

Function
REQ-010 The register file writes every cycle with no enable, so the block SHALL drive wb_reg_addr=0 and wb_data=0 in every cycle with wb_valid=0.
REQ-011 Each source SHALL own a DEPTH-entry FIFO holding {rd, data}, with a count register of width log2(DEPTH)+1.
REQ-012 x_ready SHALL be 1 iff that FIFO's count < DEPTH; it SHALL depend only on registered count, with no combinational path from the output side.
REQ-013 A push SHALL occur on cycles with x_valid && x_ready.
REQ-014 A push with rd=0 SHALL be stored with data forced to 0.
REQ-015 In a cycle with a push and a pop of the same FIFO, count SHALL be unchanged, and the pushed entry SHALL never be popped in the same cycle.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.
REQ-017 Each cycle, at most one FIFO head SHALL be granted.
REQ-018 If only one FIFO is non-empty, that FIFO SHALL be granted.
REQ-019 If both FIFOs are non-empty, grant SHALL go to the source not granted last time.
REQ-020 A 1-bit last_grant register (0=ALU, 1=load) SHALL update only on a grant.
REQ-021 The granted head SHALL be popped.
REQ-022 The popped entry SHALL be loaded into registered outputs: wb_valid<=1, wb_reg_addr<={59'b0,rd}, wb_data<=data.
REQ-023 With no grant, the registered outputs SHALL load wb_valid<=0, wb_reg_addr<=0, wb_data<=0.
REQ-024 Latency: an entry pushed at edge N into an empty FIFO with no competing head SHALL appear on the outputs after edge N+1.
REQ-025 Sustained throughput SHALL be one write per cycle.
REQ-026 Order within one source SHALL be FIFO. No ordering is guaranteed across sources; producers SHALL NOT issue same-rd writes on both ports concurrently.
REQ-027 pending_mask SHALL be the combinational OR, over all valid FIFO entries plus the output register when wb_valid=1, of one-hot(rd).
REQ-028 pending_mask bit 0 SHALL always be 0.
REQ-029 An entry SHALL be visible in pending_mask from the cycle after its push until the cycle its write is presented, inclusive.

Reset
REQ-030 While reset=1 at an edge: both counts and pointers SHALL clear to 0, last_grant<=1 (ALU wins the first tie), wb_valid<=0, wb_reg_addr<=0, wb_data<=0.
REQ-031 After reset: pending_mask=0 and alu_ready=ld_ready=1 in the next cycle.
REQ-032 A reset asserted mid-operation SHALL discard all queued entries without presenting them.
REQ-033 Pushes presented in a reset cycle SHALL be ignored.
REQ-034 FIFO storage contents need not be reset.

Verification
REQ-035 Idle: after reset, no valids for 5 cycles -> wb_valid=0, wb_reg_addr=0, wb_data=0, pending_mask=0 every cycle.
REQ-036 Single write: alu rd=5, data=0xDEAD_BEEF at edge N -> pending_mask=0x20 from N; at N+1 wb_valid=1, wb_reg_addr=5, wb_data=0xDEAD_BEEF; at N+2 pending_mask=0, outputs return to 0.
REQ-037 Tie: alu rd=1, data=0x11 and ld rd=2, data=0x22 pushed together -> writes presented rd=1 then rd=2 on consecutive cycles. Repeat with rd=3/rd=4 -> rd=3 (ALU, alternating from the last grant) then rd=4.
REQ-038 Full/backpressure: DEPTH=2, hold ld_valid with rd=7..10 while ALU floods -> ld_ready drops only at count=2; load writes emerge in order 7,8,9,10, interleaved with ALU writes, with no loss or duplication.
REQ-039 x0: ld rd=0, data=0xFFFF -> presented wb_reg_addr=0, wb_data=0, wb_valid=1; pending_mask bit 0 stays 0.
REQ-040 Reset mid-operation: both FIFOs full, assert reset for 1 cycle -> next cycle wb_valid=0, pending_mask=0, both readies=1; no pre-reset entry is ever written afterwards.
